// File: rtl/ocm_copy_master.sv
// Avalon-MM master that copies or fills a block of words in a fixed-latency on-chip memory,
// executing one command at a time.
module ocm_copy_master #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LEN_W        = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_start,
  input  logic                cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_fill,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    words_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_FIN
  } state_t;

  state_t             state;
  logic               mode;
  logic [ADDR_W-1:0]  src;
  logic [ADDR_W-1:0]  dst;
  logic [LEN_W-1:0]   remaining;
  logic [DATA_W-1:0]  wdata;
  logic [LAT_W-1:0]   lat_cnt;

  // FSM with bus outputs registered on state entry and held while the slave stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      mode           <= 1'b0;
      src            <= '0;
      dst            <= '0;
      remaining      <= '0;
      wdata          <= '0;
      lat_cnt        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      words_done     <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            mode       <= cmd_mode;
            src        <= cmd_src;
            dst        <= cmd_dst;
            remaining  <= cmd_len;
            wdata      <= cmd_fill;
            words_done <= '0;
            busy       <= 1'b1;
            if (cmd_len == '0) begin
              state <= S_FIN;
            end else if (!cmd_mode) begin
              state          <= S_RD;
              avm_read       <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_byteenable <= {BE_W{1'b1}};
              avm_address    <= cmd_src;
            end else begin
              state          <= S_WR;
              avm_write      <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_byteenable <= {BE_W{1'b1}};
              avm_address    <= cmd_dst;
              avm_writedata  <= cmd_fill;
            end
          end
        end

        S_RD: begin
          if (!avm_waitrequest) begin
            state          <= S_RD_WAIT;
            lat_cnt        <= LAT_W'(READ_LATENCY - 1);
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_byteenable <= '0;
            avm_address    <= '0;
          end
        end

        // Read data is sampled READ_LATENCY edges after the accepting edge.
        S_RD_WAIT: begin
          if (lat_cnt == '0) begin
            state          <= S_WR;
            wdata          <= avm_readdata;
            avm_write      <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_byteenable <= {BE_W{1'b1}};
            avm_address    <= dst;
            avm_writedata  <= avm_readdata;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        S_WR: begin
          if (!avm_waitrequest) begin
            dst        <= dst + 1'b1;
            words_done <= words_done + 1'b1;
            remaining  <= remaining - 1'b1;
            if (!mode) begin
              src <= src + 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
              state          <= S_FIN;
              avm_write      <= 1'b0;
              avm_chipselect <= 1'b0;
              avm_byteenable <= '0;
              avm_address    <= '0;
              avm_writedata  <= '0;
            end else if (!mode) begin
              state         <= S_RD;
              avm_write     <= 1'b0;
              avm_read      <= 1'b1;
              avm_writedata <= '0;
              avm_address   <= src + 1'b1;
            end else begin
              // FILL streams one write per cycle; addresses wrap naturally.
              avm_address   <= dst + 1'b1;
              avm_writedata <= wdata;
            end
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocm_copy_master.sv
// Directed bench for ocm_copy_master with a latency-1 memory slave model and optional stalls.
module tb_ocm_copy_master;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 12;

  logic              clk;
  logic              reset_n;
  logic              cmd_start;
  logic              cmd_mode;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_fill;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  ocm_copy_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .LEN_W(LEN_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_start      (cmd_start),
    .cmd_mode       (cmd_mode),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .cmd_len        (cmd_len),
    .cmd_fill       (cmd_fill),
    .busy           (busy),
    .done           (done),
    .words_done     (words_done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave model: latency 1, optional 3-cycle stall on every request.
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] rd_q = '0;
  logic              stall_en;
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  int                scnt = 0;
  int                gcyc = 0;
  int                rd_count = 0;
  int                wr_count = 0;
  int                both_cnt = 0;
  int                bus_viol = 0;
  int                stall_viol = 0;
  logic [ADDR_W-1:0] wr_addr_log [0:63];
  int                wr_cyc_log [0:63];
  logic              p_stalled = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic              p_rd = 1'b0;
  logic              p_wr = 1'b0;
  logic [DATA_W-1:0] p_wd = '0;

  assign avm_waitrequest = stall_en && (avm_read || avm_write) && (scnt < 3);
  assign avm_readdata    = rd_q;

  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (avm_read && avm_write) both_cnt <= both_cnt + 1;
    if (!avm_read && !avm_write &&
        (avm_address != '0 || avm_chipselect || avm_byteenable != '0 || avm_writedata != '0))
      bus_viol <= bus_viol + 1;
    if ((avm_read || avm_write) && (!avm_chipselect || avm_byteenable != 4'hF))
      bus_viol <= bus_viol + 1;
    if (avm_read || avm_write) scnt <= avm_waitrequest ? scnt + 1 : 0;
    if (avm_read && avm_chipselect && !avm_waitrequest) begin
      rd_q     <= mem[avm_address];
      rd_count <= rd_count + 1;
    end
    if (avm_write && avm_chipselect && !avm_waitrequest) begin
      mem[avm_address]           <= avm_writedata;
      wr_addr_log[wr_count[5:0]] <= avm_address;
      wr_cyc_log[wr_count[5:0]]  <= gcyc;
      wr_count                   <= wr_count + 1;
    end
    if (p_stalled && (avm_address != p_addr || avm_read != p_rd ||
                      avm_write != p_wr || avm_writedata != p_wd))
      stall_viol <= stall_viol + 1;
    p_stalled <= (avm_read || avm_write) && avm_waitrequest;
    p_addr    <= avm_address;
    p_rd      <= avm_read;
    p_wr      <= avm_write;
    p_wd      <= avm_writedata;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Drives the strobe in cycle 0; returns at the negedge of cycle 1.
  task automatic start_cmd(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] f);
    cmd_mode  = m;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    cmd_fill  = f;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_fill  = '0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int rd0;
  int wr0;
  logic [ADDR_W-1:0] fill_addr [0:3];

  initial begin
    reset_n   = 1'b0;
    cmd_start = 1'b0;
    cmd_mode  = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_fill  = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    stall_en  = 1'b0;
    fill_addr[0] = 11'h7FE;
    fill_addr[1] = 11'h7FF;
    fill_addr[2] = 11'h000;
    fill_addr[3] = 11'h001;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic COPY
    for (int i = 0; i < 4; i++) poke(11'h010 + 11'(i), 32'hA0A0_0000 + 32'(i));
    for (int i = 0; i < 5; i++) poke(11'h100 + 11'(i), 32'h0);
    rd0 = rd_count;
    wr0 = wr_count;
    start_cmd(1'b0, 11'h010, 11'h100, 12'd4, 32'h0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(1, cyc);
    check("t1_done_cyc", 32'(cyc), 32'd14);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_words", 32'(words_done), 32'd4);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) check("t1_mem", mem[11'h100 + 11'(i)], 32'hA0A0_0000 + 32'(i));
    check("t1_guard", mem[11'h104], 32'h0);
    check("t1_reads", 32'(rd_count - rd0), 32'd4);
    check("t1_writes", 32'(wr_count - wr0), 32'd4);

    // 2: COPY with 3-cycle stalls on every request
    poke(11'h020, 32'h5555_0001);
    poke(11'h021, 32'h5555_0002);
    poke(11'h120, 32'h0);
    poke(11'h121, 32'h0);
    rd0 = rd_count;
    wr0 = wr_count;
    stall_en = 1'b1;
    start_cmd(1'b0, 11'h020, 11'h120, 12'd2, 32'h0);
    wait_done(1, cyc);
    stall_en = 1'b0;
    check("t2_done_cyc", 32'(cyc), 32'd20);
    check("t2_mem0", mem[11'h120], 32'h5555_0001);
    check("t2_mem1", mem[11'h121], 32'h5555_0002);
    check("t2_reads", 32'(rd_count - rd0), 32'd2);
    check("t2_writes", 32'(wr_count - wr0), 32'd2);
    check("t2_stable", 32'(stall_viol), 32'd0);
    @(negedge clk);

    // 3: zero-length command
    rd0 = rd_count;
    wr0 = wr_count;
    start_cmd(1'b0, 11'h010, 11'h100, 12'd0, 32'h0);
    check("t3_busy", 32'(busy), 32'd1);
    wait_done(1, cyc);
    check("t3_done_cyc", 32'(cyc), 32'd2);
    check("t3_words", 32'(words_done), 32'd0);
    check("t3_reads", 32'(rd_count - rd0), 32'd0);
    check("t3_writes", 32'(wr_count - wr0), 32'd0);
    @(negedge clk);

    // 4: FILL across the address wrap
    for (int i = 0; i < 4; i++) poke(fill_addr[i], 32'h0);
    poke(11'h002, 32'h0);
    wr0 = wr_count;
    start_cmd(1'b1, 11'h000, 11'h7FE, 12'd4, 32'hDEAD_BEEF);
    wait_done(1, cyc);
    check("t4_done_cyc", 32'(cyc), 32'd6);
    check("t4_writes", 32'(wr_count - wr0), 32'd4);
    check("t4_words", 32'(words_done), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_addr", 32'(wr_addr_log[(wr0 + i) % 64]), 32'(fill_addr[i]));
      check("t4_mem", mem[fill_addr[i]], 32'hDEAD_BEEF);
    end
    for (int i = 1; i < 4; i++)
      check("t4_b2b", 32'(wr_cyc_log[(wr0 + i) % 64] - wr_cyc_log[(wr0 + i - 1) % 64]), 32'd1);
    check("t4_guard", mem[11'h002], 32'h0);
    @(negedge clk);

    // 5: reset during RD_WAIT, then a fresh command
    for (int i = 0; i < 8; i++) poke(11'h030 + 11'(i), 32'hC000_0030 + 32'(i));
    poke(11'h300, 32'h1111_1111);
    poke(11'h310, 32'h0);
    poke(11'h311, 32'h0);
    start_cmd(1'b0, 11'h030, 11'h300, 12'd8, 32'h0);
    @(negedge clk);
    check("t5_in_rdwait", 32'(avm_read), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_req", 32'({avm_read, avm_write, avm_chipselect}), 32'd0);
    check("t5_addr", 32'(avm_address), 32'd0);
    check("t5_be", 32'(avm_byteenable), 32'd0);
    check("t5_wdata", avm_writedata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_no_done_rel", 32'(done), 32'd0);
    check("t5_untouched", mem[11'h300], 32'h1111_1111);
    start_cmd(1'b0, 11'h034, 11'h310, 12'd2, 32'h0);
    wait_done(1, cyc);
    check("t5_done_cyc", 32'(cyc), 32'd8);
    check("t5_mem0", mem[11'h310], 32'hC000_0034);
    check("t5_mem1", mem[11'h311], 32'hC000_0035);
    check("t5_words", 32'(words_done), 32'd2);
    @(negedge clk);

    // 6: start strobe while busy is ignored
    for (int i = 0; i < 3; i++) poke(11'h040 + 11'(i), 32'hB000_0040 + 32'(i));
    for (int i = 0; i < 4; i++) poke(11'h140 + 11'(i), 32'h0);
    wr0 = wr_count;
    start_cmd(1'b0, 11'h040, 11'h140, 12'd3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    start_cmd(1'b1, 11'h000, 11'h140, 12'd5, 32'h1234_5678);
    wait_done(4, cyc);
    check("t6_done_cyc", 32'(cyc), 32'd11);
    check("t6_words", 32'(words_done), 32'd3);
    check("t6_writes", 32'(wr_count - wr0), 32'd3);
    for (int i = 0; i < 3; i++) check("t6_mem", mem[11'h140 + 11'(i)], 32'hB000_0040 + 32'(i));
    check("t6_guard", mem[11'h143], 32'h0);
    @(negedge clk);
    check("t6_idle", 32'(busy), 32'd0);

    check("rd_wr_exclusive", 32'(both_cnt), 32'd0);
    check("bus_idle_zero", 32'(bus_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
